// File: rtl/halflife_sequencer_if.sv
// Control/feedback bus between the half-life sequencer and its up/down counter.
interface halflife_sequencer_if #(
  parameter int N = 4
);
  logic [N-1:0] cnt_q;
  logic [N-1:0] cnt_in;
  logic         cnt_rst;
  logic         cnt_load;
  logic         cnt_up;
  logic         cnt_down;

  modport master (
    input  cnt_q,
    output cnt_rst, cnt_load, cnt_in, cnt_up, cnt_down
  );

  modport slave (
    output cnt_q,
    input  cnt_rst, cnt_load, cnt_in, cnt_up, cnt_down
  );
endinterface

// File: rtl/halflife_sequencer.sv
// Sequencer for the half-life counter: loads a start quantity, then applies one
// decay step (halve or decrement) per half-life until the counter reads zero.
module halflife_sequencer #(
  parameter int N        = 4,
  parameter int PRESCALE = 1000,
  parameter int HL_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  mode,
  input  logic [N-1:0]          init_val,
  input  logic [HL_W-1:0]       hl_period,
  halflife_sequencer_if.master  ctr,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            steps
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_STEP, S_DONE} state_t;

  // Half-life length is kept as its last index so expiry is a plain compare.
  typedef struct packed {
    logic            mode;
    logic [HL_W-1:0] hl_last;
  } cfg_t;

  state_t          state_q, state_d;
  cfg_t            cfg_q, cfg_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [HL_W-1:0] hl_q, hl_d;
  logic [3:0]      steps_q, steps_d;
  logic            rst_q, rst_d;
  logic            load_q, load_d;
  logic            down_q, down_d;
  logic [N-1:0]    in_q, in_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            tick;

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    pre_d   = pre_q;
    hl_d    = hl_q;
    steps_d = steps_q;
    rst_d   = 1'b0;
    load_d  = 1'b0;
    down_d  = 1'b0;
    in_d    = '0;
    tick    = (pre_q == PRE_LAST);

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      rst_d   = 1'b1;
      steps_d = '0;
      pre_d   = '0;
      hl_d    = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d       = S_LOAD;
            cfg_d.mode    = mode;
            cfg_d.hl_last = (hl_period == '0) ? '0 : hl_period - 1'b1;
            steps_d       = '0;
            load_d        = 1'b1;
            in_d          = init_val;
          end
        end
        S_LOAD: begin
          state_d = S_RUN;
          pre_d   = '0;
          hl_d    = '0;
        end
        S_RUN: begin
          // Zero wins over a tick expiring in the same cycle.
          if (ctr.cnt_q == '0) begin
            state_d = S_DONE;
          end else begin
            pre_d = tick ? '0 : pre_q + 1'b1;
            if (tick) begin
              if (hl_q == cfg_q.hl_last) begin
                hl_d    = '0;
                state_d = S_STEP;
                if (steps_q != 4'hF) steps_d = steps_q + 4'd1;
                if (cfg_q.mode) begin
                  down_d = 1'b1;
                end else begin
                  load_d = 1'b1;
                  in_d   = ctr.cnt_q >> 1;
                end
              end else begin
                hl_d = hl_q + 1'b1;
              end
            end
          end
        end
        S_STEP:  state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d == S_LOAD) || (state_d == S_RUN) || (state_d == S_STEP);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cfg_q   <= '0;
      pre_q   <= '0;
      hl_q    <= '0;
      steps_q <= '0;
      rst_q   <= 1'b0;
      load_q  <= 1'b0;
      down_q  <= 1'b0;
      in_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      pre_q   <= pre_d;
      hl_q    <= hl_d;
      steps_q <= steps_d;
      rst_q   <= rst_d;
      load_q  <= load_d;
      down_q  <= down_d;
      in_q    <= in_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ctr.cnt_rst  = rst_q;
  assign ctr.cnt_load = load_q;
  assign ctr.cnt_in   = in_q;
  assign ctr.cnt_down = down_q;
  assign ctr.cnt_up   = 1'b0;
  assign busy         = busy_q;
  assign done         = done_q;
  assign steps        = steps_q;

endmodule
